// File: rtl/types_pkg.sv
// types_pkg: shared bus width, fetch-queue entry layout and word size.
//   DATA_W        : data/address bus width in bits
//   DATA_BUS      : bus-wide vector type
//   WORD_BYTES    : bytes per instruction word (fetch PC stride)
//   FETCH_Q_ENTRY : one prefetch entry {pc, instr}
package types_pkg;
    localparam int DATA_W = 32;
    localparam int WORD_BYTES = 4;
    typedef logic [DATA_W-1:0] DATA_BUS;
    typedef struct packed {
        DATA_BUS pc;
        DATA_BUS instr;
    } FETCH_Q_ENTRY;
endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of FETCH_Q_ENTRY with flush and combinational head read.
//   clk, rst   : clock, synchronous active-high reset
//   flush_i    : drop all entries (head pointer snaps to tail)
//   push_i     : write wdata_i at tail
//   wdata_i    : entry to write
//   pop_i      : advance head
//   rdata_o    : head entry (no read latency)
//   count_o    : number of valid entries
module fetch_fifo
    import types_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  FETCH_Q_ENTRY wdata_i,
    input  logic         pop_i,
    output FETCH_Q_ENTRY rdata_o,
    output logic [CW-1:0] count_o
);
    FETCH_Q_ENTRY mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic wr_en;

    assign wr_en = push_i && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = flush_i ? wr_ptr_q : wr_ptr_q + AW'(push_i);
        rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + AW'(pop_i);
        count_d  = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with redirect/flush in front of decode.
//   clk, rst       : clock, synchronous active-high reset
//   rom_addr       : byte address to the instruction ROM (= fetch_pc)
//   rom_dout       : ROM word for rom_addr, same cycle
//   redirect_valid : taken branch/jump, flush and refetch from redirect_pc
//   redirect_pc    : new fetch address (low two bits ignored)
//   instr_valid    : head entry valid for decode
//   instr_ready    : decode accepts head entry
//   instr/instr_pc : head instruction word and its byte address
//   stall_cycles   : saturating count of cycles decode was ready but starved;
//                    present only when FETCH_STALL_CNT_EN is defined
module fetch_queue
    import types_pkg::*;
#(
    parameter int      DEPTH    = 4,
    parameter DATA_BUS RESET_PC = 32'h0000_0000,
    localparam int     CW       = $clog2(DEPTH) + 1
) (
    input  logic    clk,
    input  logic    rst,
    output DATA_BUS rom_addr,
    input  DATA_BUS rom_dout,
    input  logic    redirect_valid,
    input  DATA_BUS redirect_pc,
    output logic    instr_valid,
    input  logic    instr_ready,
    output DATA_BUS instr,
    output DATA_BUS instr_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output DATA_BUS stall_cycles
`endif
);
    DATA_BUS fetch_pc_q, fetch_pc_d;
    FETCH_Q_ENTRY head, wentry;
    logic [CW-1:0] count;
    logic push, pop;
    logic unused_pc_lsb;

    // Redirect targets are word-aligned, so the two byte-offset bits are dropped.
    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign rom_addr    = fetch_pc_q;
    assign instr_valid = (count != '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    // A full queue can still accept a fetch when the head leaves in the same cycle.
    assign push        = !redirect_valid && ((count < CW'(DEPTH)) || pop);
    assign wentry      = '{pc: fetch_pc_q, instr: rom_dout};
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_comb begin
        fetch_pc_d = redirect_valid ? {redirect_pc[DATA_W-1:2], 2'b00}
                   : push           ? fetch_pc_q + DATA_W'(WORD_BYTES)
                   :                  fetch_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

`ifdef FETCH_STALL_CNT_EN
    DATA_BUS stall_q, stall_d;

    assign stall_cycles = stall_q;

    always_comb begin
        stall_d = (instr_ready && !instr_valid && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    import types_pkg::*;

    localparam int DEPTH = 4;
    localparam DATA_BUS RST_PC = 32'h0000_0000;
    localparam DATA_BUS ROM_KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst, redirect_valid, instr_ready, instr_valid;
    DATA_BUS rom_addr, rom_dout, redirect_pc, instr, instr_pc;
`ifdef FETCH_STALL_CNT_EN
    DATA_BUS stall_cycles;
`endif

    int total = 0;
    int bad = 0;

    DATA_BUS exp_q[$];
    DATA_BUS model_pc = RST_PC;
    DATA_BUS model_stall = '0;
    bit armed = 0;
    bit pop_seen = 0;
    bit valid_seen = 0;
    int size_seen = 0;

    always #5 clk = ~clk;

    assign rom_dout = rom_addr ^ ROM_KEY;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    task automatic chk(input string name, input DATA_BUS act, input DATA_BUS req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: samples mid-cycle, compares against model state, consumes one
    // expected entry whenever the handshake fires.
    always @(negedge clk) begin
        pop_seen = 0;
        if (armed) begin
            size_seen  = exp_q.size();
            valid_seen = (size_seen != 0) && !redirect_valid;
            chk("rom_addr", rom_addr, model_pc);
            chk("instr_valid", DATA_BUS'(instr_valid), DATA_BUS'(valid_seen));
`ifdef FETCH_STALL_CNT_EN
            chk("stall_cycles", stall_cycles, model_stall);
`endif
            if (valid_seen && instr_ready) begin
                pop_seen = 1;
                chk("instr_pc", instr_pc, exp_q[0]);
                chk("instr", instr, exp_q[0] ^ ROM_KEY);
                void'(exp_q.pop_front());
            end
        end
    end

    // Reference model: a plain queue of fetch addresses advanced once per edge
    // from the inputs held during the cycle that just ended.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_pc    = RST_PC;
            model_stall = '0;
            armed       = 1;
        end else if (armed) begin
            if (instr_ready && !valid_seen && model_stall != '1) model_stall = model_stall + 1;
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
            end else if (size_seen < DEPTH || pop_seen) begin
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
    end

    task automatic step(input bit r, input bit rv, input DATA_BUS rpc, input bit rdy, input int n);
        rst = r;
        redirect_valid = rv;
        redirect_pc = rpc;
        instr_ready = rdy;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 0, '0, 0, 2);
        step(0, 0, '0, 1, 8);
        step(1, 0, '0, 0, 1);
        step(0, 0, '0, 0, 10);
        step(0, 0, '0, 1, 8);
        step(0, 0, '0, 0, 6);
        step(0, 1, 32'h0000_0103, 1, 1);
        step(0, 0, '0, 1, 4);
        step(0, 1, 32'hFFFF_FFF8, 1, 1);
        step(0, 0, '0, 1, 6);
        step(0, 0, '0, 0, 3);
        step(1, 0, '0, 1, 1);
        step(0, 0, '0, 1, 2);
        step(0, 1, 32'h0000_0200, 1, 3);
        step(0, 0, '0, 1, 3);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom,
                 ($urandom_range(0, 99) < 70),
                 1);
        end
        step(0, 0, '0, 1, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
